// File: rtl/pin_capture.sv
// Pin capture: synchronizes pin_in, detects rising edges, and reports the first
// edge phase of each 8-cycle frame. Optional glitch filter: PIN_CAPT_FILTER_EN.
module pin_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 3
) (
    input  logic       clk600,
    input  logic       rst_n,
    input  logic       pin_in,
    output logic       pin_out,
    output logic       str,
    output logic [2:0] ptime
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("pin_capture: SYNC_STAGES must be 2..4");
    end
    if (MIN_WIDTH < 1 || MIN_WIDTH > 15) begin : g_bad_width
        $error("pin_capture: MIN_WIDTH must be 1..15");
    end

    logic [2:0]             ph;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last;
    logic                   level;
    logic                   level_prev;
    logic                   edge_hit;
    logic                   ev;
    logic [2:0]             cap;

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk600 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
        end
    end

`ifdef PIN_CAPT_FILTER_EN
    logic [3:0] filt_cnt;
    logic       filt_q;

    // The output level only moves once the new level has persisted MIN_WIDTH cycles.
    always_ff @(posedge clk600 or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= 4'd0;
            filt_q   <= 1'b0;
        end else if (sync_last == filt_q) begin
            filt_cnt <= 4'd0;
        end else if (filt_cnt == 4'(MIN_WIDTH - 1)) begin
            filt_cnt <= 4'd0;
            filt_q   <= sync_last;
        end else begin
            filt_cnt <= filt_cnt + 4'd1;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_last;
`endif

    assign pin_out  = level;
    assign edge_hit = level & ~level_prev;

    always_ff @(posedge clk600 or negedge rst_n) begin
        if (!rst_n) begin
            ph         <= 3'd0;
            level_prev <= 1'b0;
            ev         <= 1'b0;
            cap        <= 3'd0;
            str        <= 1'b0;
            ptime      <= 3'd0;
        end else begin
            ph         <= ph + 3'd1;
            level_prev <= level;
            str        <= 1'b0;
            if (ph == 3'd7) begin
                // An edge in the last cycle still belongs to the closing frame.
                str <= ev | edge_hit;
                if (ev) begin
                    ptime <= cap;
                end else if (edge_hit) begin
                    ptime <= ph;
                end
                ev <= 1'b0;
            end else if (edge_hit && !ev) begin
                cap <= ph;
                ev  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pin_capture.sv
// Bench for pin_capture: table-driven per-cycle vectors through an expectation
// queue, plus a hand-written mid-frame reset sequence.
module tb_pin_capture;

    logic       clk600;
    logic       rst_n;
    logic       pin_in;
    logic       pin_out;
    logic       str;
    logic [2:0] ptime;

    pin_capture #(.SYNC_STAGES(2), .MIN_WIDTH(3)) dut (
        .clk600  (clk600),
        .rst_n   (rst_n),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .str     (str),
        .ptime   (ptime)
    );

    initial clk600 = 1'b0;
    always #5 clk600 = ~clk600;

    typedef struct {
        bit       rst_before;
        bit       pin;
        bit       po;
        bit       st;
        bit [2:0] pt;
    } vec_t;

    typedef struct {
        bit       po;
        bit       st;
        bit [2:0] pt;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   str_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add_row(input bit r, input bit p, input bit po,
                                    input bit st, input bit [2:0] pt);
        vec_t v;
        v.rst_before = r;
        v.pin        = p;
        v.po         = po;
        v.st         = st;
        v.pt         = pt;
        tbl.push_back(v);
    endfunction

    // Called at a falling edge; leaves rst_n released just before edge 1.
    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pin_in = (i % 2 == 0);
            @(posedge clk600);
            @(negedge clk600);
            chk("rst_pin_out", pin_out, 0);
            chk("rst_str", str, 0);
            chk("rst_ptime", ptime, 0);
        end
        rst_n  = 1'b1;
        pin_in = 1'b0;
    endtask

    task automatic apply(input bit p, input bit po, input bit st, input bit [2:0] pt,
                         input string tag);
        exp_t e;
        exp_t got;
        pin_in = p;
        e.po = po;
        e.st = st;
        e.pt = pt;
        exp_q.push_back(e);
        @(posedge clk600);
        @(negedge clk600);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation queue empty", tag);
        end else begin
            got = exp_q.pop_front();
            chk({tag, "_pin_out"}, pin_out, got.po);
            chk({tag, "_str"}, str, got.st);
            chk({tag, "_ptime"}, ptime, got.pt);
        end
    endtask

    always @(negedge clk600) begin
        if (rst_n && str) begin
            chk("str_two_cycles", str_prev, 0);
        end
        str_prev = rst_n & str;
    end

    initial begin
        rst_n  = 1'b0;
        pin_in = 1'b0;

`ifdef PIN_CAPT_FILTER_EN
        // 2-cycle pulse is swallowed by the filter.
        for (int k = 1; k <= 16; k++)
            add_row(k == 1, (k == 3 || k == 4), 1'b0, 1'b0, 3'd0);
        // 5-cycle pulse: pin_out high after edges 7..11, edge cycle ph=7.
        for (int k = 1; k <= 16; k++)
            add_row(k == 1, (k >= 3 && k <= 7), (k >= 7 && k <= 11), (k == 8),
                    (k >= 8) ? 3'd7 : 3'd0);
`else
        // Single edge at ph=4, then a second rise at ph=5 of the next frame, then a quiet frame.
        for (int k = 1; k <= 24; k++)
            add_row(k == 1, ((k >= 3 && k <= 9) || k >= 12),
                    ((k >= 4 && k <= 10) || k >= 13), (k == 8 || k == 16),
                    (k < 8) ? 3'd0 : ((k < 16) ? 3'd4 : 3'd5));
        // Edge in the ph=7 cycle reports with the closing frame.
        for (int k = 1; k <= 10; k++)
            add_row(k == 1, (k >= 6), (k >= 7), (k == 8), (k >= 8) ? 3'd7 : 3'd0);
        // Empty first frame, two edges (ph=1, ph=5) in the second, quiet third.
        for (int k = 1; k <= 25; k++)
            add_row(k == 1, (k == 8 || k == 9 || k >= 12), (k == 9 || k == 10 || k >= 13),
                    (k == 16), (k >= 16) ? 3'd1 : 3'd0);
`endif

        @(negedge clk600);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) do_reset();
            apply(tbl[i].pin, tbl[i].po, tbl[i].st, tbl[i].pt, $sformatf("row%0d", i));
        end

`ifndef PIN_CAPT_FILTER_EN
        // Edge at ph=2, then reset asserted during the ph=4 cycle.
        do_reset();
        for (int k = 1; k <= 4; k++)
            apply(1'b1, (k >= 2), 1'b0, 3'd0, $sformatf("midrst_pre%0d", k));
        rst_n = 1'b0;
        #1;
        chk("midrst_pin_out", pin_out, 0);
        chk("midrst_str", str, 0);
        chk("midrst_ptime", ptime, 0);
        @(negedge clk600);
        rst_n  = 1'b1;
        pin_in = 1'b0;
        for (int k = 1; k <= 12; k++)
            apply(1'b0, 1'b0, 1'b0, 3'd0, $sformatf("midrst_post%0d", k));
`endif

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_expectations: got %0d, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pin_capture.md
# pin_capture

Single-clock pulse-arrival capture block. It conditions one asynchronous input pin and finds its rising edges. Each edge is time-stamped to a clock-cycle phase inside a repeating 8-cycle frame, and reported once per frame as a strobe plus a 3-bit phase code. It sits between a raw detector/trigger pin and downstream timing/histogram logic running on the same clock.

## Interface
- SYNC_STAGES, default 2: number of synchronizer flops on pin_in; legal range 2..4.
- MIN_WIDTH, default 3: glitch-filter stability length in cycles; legal range 1..15; used only when the filter is compiled in.
- clk600  input  1: sole clock; all logic on its rising edge.
- rst_n  input  1: asynchronous, active-low reset; deassertion synchronous to clk600 externally.
- pin_in  input  1: asynchronous pin to capture.
- pin_out  output  1: conditioned (synchronized, optionally filtered) level of pin_in.
- str  output  1: one-cycle strobe; a rising edge occurred in the frame just ended.
- ptime  output  3: phase (0..7) of the first rising edge in the reported frame; valid with str and held until the next str.

## Operation
- Phase counter ph, 3 bits, free-running, increments every cycle, wraps 7→0. A frame is the 8 cycles with ph = 0..7.
- Synchronizer: SYNC_STAGES flops, reset to 0. Without the filter, pin_out = last synchronizer stage.
- Edge cycle: a cycle in which pin_out = 1 and pin_out was 0 in the previous cycle. Falling edges are ignored.
- Per-frame capture: the first edge cycle of a frame stores ph into cap and sets flag ev. Later edges in the same frame are discarded. An edge in the ph = 7 cycle belongs to the current frame.
- Report: at the clock edge where ph goes 7→0, str ← ev and ptime ← cap if ev = 1. ev is then cleared, and the incoming frame starts empty.
- If no edge occurred in a frame, str stays 0 and ptime keeps its old value.
- If pin_in is high when reset is released, it produces a rising edge once the synchronizer fills, because the reset level is 0.

## Timing
- Reset values: ph = 0, synchronizer = 0, pin_out = 0, str = 0, ptime = 0, ev = 0, cap = 0, filter counter = 0.
- Reset asserted mid-frame discards any pending event; no str is issued for that frame.
- ph after the n-th post-reset clock edge = n mod 8.
- pin_in→pin_out latency without the filter: pin_in high at edge E gives pin_out high after edge E+SYNC_STAGES−1.
- Edge→str latency: str is high for exactly the one cycle after the first 7→0 wrap at or following the edge cycle. Maximum latency is 8 cycles.
- Back-to-back frames may each produce str; str is never high two consecutive cycles.

## Configuration
- PIN_CAPT_FILTER_EN defined: a glitch filter sits between the synchronizer and pin_out.
  - pin_out takes a new value only after the last synchronizer stage has differed from pin_out for MIN_WIDTH consecutive cycles.
  - The counter resets whenever the stage equals pin_out.
  - This adds MIN_WIDTH cycles of latency. Pulses shorter than MIN_WIDTH cycles are suppressed entirely, with no pin_out change and no str.
- PIN_CAPT_FILTER_EN undefined: pin_out = last synchronizer stage; MIN_WIDTH has no effect.

## Test plan
All scenarios use SYNC_STAGES = 2 and the filter off unless stated.
- Reset check: hold rst_n = 0 with pin_in toggling → pin_out = 0, str = 0, ptime = 0 throughout.
- Single edge: after reset release, pin_in high before edge 3 → pin_out high after edge 4, edge cycle ph = 4; str high only between edges 8 and 9, ptime = 4, held afterward.
- Frame boundary: pin_out rises in the ph = 7 cycle (pin_in high before edge 6) → str after edge 8 with ptime = 7.
- Multiple edges: two rising edges at ph = 1 and ph = 5 of one frame → one str, ptime = 1. The next frame with no edge gives str = 0 and ptime = 1 retained.
- Reset mid-frame: edge at ph = 2, rst_n pulsed low at ph = 4 → no str, all outputs return to 0.
- Filter on (PIN_CAPT_FILTER_EN, MIN_WIDTH = 3): 2-cycle pin_in pulse → no pin_out change, no str. A 5-cycle pulse → pin_out high 3 cycles later than unfiltered, one str.
